// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small write FIFO
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BPS        = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int DIVIDER_CNT = CLK_FREQ / (BPS * 16);
    localparam int BAUD_W      = (DIVIDER_CNT > 1) ? $clog2(DIVIDER_CNT) : 1;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic [7:0]        rd_data;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              tick;
    logic              bit_end;

    // A full FIFO drops the push even when the FSM pops in the same cycle.
    assign push    = wr_en & ~full;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

    assign tick    = (baud_cnt == BAUD_W'(DIVIDER_CNT - 1));
    assign bit_end = tick && (tick_cnt == 4'd15);
    assign tx_done = (state == STOP) && bit_end;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop always starts a fresh frame: start bit driven, all bit timing restarted.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            tx_busy  <= 1'b0;
            tx       <= 1'b1;
            shift    <= '0;
            baud_cnt <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state   <= state_next;
            tx_busy <= (state_next != IDLE);
            if (pop) begin
                shift    <= rd_data;
                tx       <= 1'b0;
                baud_cnt <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                if (state == IDLE || tick) begin
                    baud_cnt <= '0;
                end else begin
                    baud_cnt <= baud_cnt + BAUD_W'(1);
                end
                if (state != IDLE && tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                end
                case (state)
                    START: begin
                        if (bit_end) begin
                            tx <= shift[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= (bit_cnt == 3'd7) ? 1'b1 : shift[1];
                        end
                    end
                    STOP: tx <= 1'b1;
                    default: tx <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo with a serial-line frame decoder
module tb_uart_tx_fifo;
    logic       PCLK;
    logic       PRESETn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;

    logic [7:0] exp_q [$];
    int done_cnt  = 0;
    int frame_cnt = 0;
    int idle_cnt  = 0;
    int stray_cnt = 0;

    uart_tx_fifo #(
        .CLK_FREQ  (100_000_000),
        .BPS       (1_562_500),
        .FIFO_DEPTH(4)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .tx     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - base < n) step();
    endtask

    // Frame decoder: every cycle of every bit must hold the expected level for 64 cycles.
    logic       in_frame = 1'b0;
    int         pos      = 0;
    logic [7:0] cur      = '0;
    logic [7:0] rx       = '0;
    logic       bit_ok   = 1'b1;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            in_frame = 1'b0;
        end else begin
            if (tx_done === 1'b1) done_cnt++;
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    bit_ok   = 1'b1;
                    frame_cnt++;
                    chk("expected_frame_pending", 32'(exp_q.size() != 0), 32'd1);
                    cur = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
                end else begin
                    idle_cnt++;
                    if (tx_done === 1'b1) stray_cnt++;
                end
            end
            if (in_frame) begin
                automatic int   b = pos / 64;
                automatic logic eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
                if (tx !== eb) bit_ok = 1'b0;
                if (b >= 1 && b <= 8 && pos % 64 == 32) rx[b-1] = tx;
                if (pos == 639) chk("done_at_stop_end", 32'(tx_done), 32'd1);
                else if (tx_done === 1'b1) stray_cnt++;
                if (pos % 64 == 63) begin
                    chk($sformatf("bit_level_b%0d_byte%0h", b, cur), 32'(bit_ok), 32'd1);
                    bit_ok = 1'b1;
                end
                if (pos == 639) begin
                    chk("frame_byte", 32'(rx), 32'(cur));
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    in_frame = 1'b0;
                end
                pos++;
            end
        end
    end

    initial begin
        automatic logic [7:0] vals [6] = '{8'h55, 8'h0F, 8'hF0, 8'h00, 8'hAA, 8'h33};
        int idle0, done0, frame0;
        PRESETn = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset state, then release with no writes
        repeat (3) step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        PRESETn = 1'b1;
        repeat (5) step();
        chk("rel_tx", 32'(tx), 32'd1);
        chk("rel_busy", 32'(tx_busy), 32'd0);
        chk("rel_empty", 32'(empty), 32'd1);
        chk("rel_full", 32'(full), 32'd0);

        // Single byte A5
        base = cyc;
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        wr_en = 1'b0;
        chk("t2_c1_empty", 32'(empty), 32'd0);
        chk("t2_c1_tx", 32'(tx), 32'd1);
        chk("t2_c1_busy", 32'(tx_busy), 32'd0);
        step();
        chk("t2_c2_tx", 32'(tx), 32'd0);
        chk("t2_c2_busy", 32'(tx_busy), 32'd1);
        chk("t2_c2_empty", 32'(empty), 32'd1);
        wait_rel(65);
        chk("t2_c65_tx", 32'(tx), 32'd0);
        step();
        chk("t2_c66_tx", 32'(tx), 32'd1);
        wait_rel(130);
        chk("t2_c130_tx", 32'(tx), 32'd0);
        wait_rel(641);
        chk("t2_c641_done", 32'(tx_done), 32'd1);
        chk("t2_c641_tx", 32'(tx), 32'd1);
        chk("t2_c641_busy", 32'(tx_busy), 32'd1);
        step();
        chk("t2_c642_done", 32'(tx_done), 32'd0);
        chk("t2_c642_busy", 32'(tx_busy), 32'd0);
        repeat (10) step();

        // Back-to-back frames plus a dropped write into a full FIFO
        base = cyc;
        idle0 = 0; done0 = 0; frame0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                idle0 = idle_cnt; done0 = done_cnt; frame0 = frame_cnt;
            end
            if (i == 5) chk("t3_full_c5", 32'(full), 32'd1);
            wr_en = 1'b1; wr_data = vals[i];
            if (i < 5) exp_q.push_back(vals[i]);
            step();
        end
        wr_en = 1'b0;
        chk("t3_full_c6", 32'(full), 32'd1);
        wait_rel(3202);
        chk("t3_no_gap", 32'(idle_cnt - idle0), 32'd0);
        chk("t3_done_pulses", 32'(done_cnt - done0), 32'd5);
        chk("t3_frames", 32'(frame_cnt - frame0), 32'd5);
        chk("t3_all_sent", 32'(exp_q.size()), 32'd0);
        chk("t3_busy_end", 32'(tx_busy), 32'd0);
        chk("t3_empty_end", 32'(empty), 32'd1);
        chk("t3_full_end", 32'(full), 32'd0);
        repeat (10) step();

        // Push on the same cycle the FSM pops at the end of STOP
        base = cyc;
        wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
        step();
        wr_data = 8'hC3; exp_q.push_back(8'hC3);
        step();
        wr_en = 1'b0;
        wait_rel(641);
        chk("t4_done", 32'(tx_done), 32'd1);
        chk("t4_empty_pre", 32'(empty), 32'd0);
        wr_en = 1'b1; wr_data = 8'h96; exp_q.push_back(8'h96);
        step();
        wr_en = 1'b0;
        chk("t4_empty_post", 32'(empty), 32'd0);
        chk("t4_full_post", 32'(full), 32'd0);
        chk("t4_tx_start", 32'(tx), 32'd0);
        chk("t4_busy", 32'(tx_busy), 32'd1);
        wait_rel(1925);
        chk("t4_all_sent", 32'(exp_q.size()), 32'd0);
        chk("t4_busy_end", 32'(tx_busy), 32'd0);
        chk("t4_empty_end", 32'(empty), 32'd1);

        // Asynchronous reset during DATA bit 3 (a low bit of A5)
        base = cyc;
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        wr_data = 8'h77; exp_q.push_back(8'h77);
        step();
        wr_en = 1'b0;
        wait_rel(280);
        chk("t5_tx_bit3", 32'(tx), 32'd0);
        chk("t5_empty_pre", 32'(empty), 32'd0);
        chk("t5_busy_pre", 32'(tx_busy), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("t5_async_tx", 32'(tx), 32'd1);
        chk("t5_async_empty", 32'(empty), 32'd1);
        chk("t5_async_busy", 32'(tx_busy), 32'd0);
        exp_q.delete();
        done0 = done_cnt; frame0 = frame_cnt;
        repeat (3) step();
        PRESETn = 1'b1;
        for (int i = 0; i < 700; i++) begin
            step();
            if (i % 100 == 0) chk($sformatf("t5_tx_idle_%0d", i), 32'(tx), 32'd1);
        end
        chk("t5_no_done", 32'(done_cnt - done0), 32'd0);
        chk("t5_no_frame", 32'(frame_cnt - frame0), 32'd0);
        chk("t5_busy", 32'(tx_busy), 32'd0);
        chk("stray_done", 32'(stray_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
